// File: rtl/fsm_tb_pkg.sv
// Shared definitions for the FSM stimulus player and response checker:
// checker state encoding and the sequence geometry both sides agree on.
package fsm_tb_pkg;

    localparam int FSM_IN_LEN  = 7;
    localparam int FSM_OUT_LEN = 19;
    localparam int SEQ_DEPTH   = 200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

endpackage

// File: rtl/resp_table.sv
// Expected-response storage: one {mask, data} word per sequence index.
// Synchronous write, combinational read. Contents survive reset so a
// pass can be re-run without reloading.
module resp_table #(
    parameter int W      = 38,
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [W-1:0]      rdata
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [W-1:0] mem_r [DEPTH];
    logic         rd_ok_s;

    assign rd_ok_s = ({1'b0, raddr} < DEPTH_W);
    assign rdata   = rd_ok_s ? mem_r[raddr] : {W{1'b0}};

    // Table write port; the caller has already range-checked waddr.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/fsm_resp_checker.sv
// Response checker for the fsm output stream. Compares each sampled word
// against a masked expected table, counts mismatches (saturating), keeps
// the first failing index and publishes a registered pass/fail verdict.
module fsm_resp_checker
    import fsm_tb_pkg::*;
#(
    parameter int OUT_LEN = FSM_OUT_LEN,
    parameter int DEPTH   = SEQ_DEPTH,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exp_we,
    input  logic [ADDR_W-1:0]  exp_addr,
    input  logic [OUT_LEN-1:0] exp_data,
    input  logic [OUT_LEN-1:0] exp_mask,
    input  logic               start,
    input  logic               smp,
    input  logic [OUT_LEN-1:0] dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CNT_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_err_idx,
    output logic               first_err_vld
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    chk_state_t         state_r, state_nxt_s;
    logic [ADDR_W-1:0]  idx_r, idx_nxt_s;
    logic [CNT_W-1:0]   err_r, err_nxt_s;
    logic [ADDR_W-1:0]  fidx_r, fidx_nxt_s;
    logic               fvld_r, fvld_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               pass_r, pass_nxt_s;

    logic [2*OUT_LEN-1:0] rd_word_s;
    logic [OUT_LEN-1:0]   rd_data_s, rd_mask_s;
    logic                 mis_s, addr_ok_s, tbl_we_s;

    // Writes are only accepted outside a pass and inside the table.
    assign addr_ok_s = ({1'b0, exp_addr} < DEPTH_W);
    assign tbl_we_s  = exp_we & (state_r != RUN) & addr_ok_s;

    resp_table #(
        .W      (2 * OUT_LEN),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we_s),
        .waddr (exp_addr),
        .wdata ({exp_mask, exp_data}),
        .raddr (idx_r),
        .rdata (rd_word_s)
    );

    assign {rd_mask_s, rd_data_s} = rd_word_s;
    assign mis_s = |((dut_out ^ rd_data_s) & rd_mask_s);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        err_nxt_s   = err_r;
        fidx_nxt_s  = fidx_r;
        fvld_nxt_s  = fvld_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = done_r;
        pass_nxt_s  = pass_r;
        case (state_r)
            IDLE, DONE: begin
                // start wins over a same-cycle smp, which is not consumed
                if (start) begin
                    state_nxt_s = RUN;
                    idx_nxt_s   = {ADDR_W{1'b0}};
                    err_nxt_s   = {CNT_W{1'b0}};
                    fidx_nxt_s  = {ADDR_W{1'b0}};
                    fvld_nxt_s  = 1'b0;
                    busy_nxt_s  = 1'b1;
                    done_nxt_s  = 1'b0;
                    pass_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (smp) begin
                    if (mis_s) begin
                        if (err_r != {CNT_W{1'b1}}) begin
                            err_nxt_s = err_r + CNT_W'(1);
                        end else begin
                            err_nxt_s = err_r;
                        end
                        if (!fvld_r) begin
                            fidx_nxt_s = idx_r;
                            fvld_nxt_s = 1'b1;
                        end else begin
                            fvld_nxt_s = fvld_r;
                        end
                    end else begin
                        err_nxt_s = err_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = DONE;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = (err_nxt_s == {CNT_W{1'b0}});
                    end else begin
                        idx_nxt_s   = idx_r + ADDR_W'(1);
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
                pass_nxt_s  = 1'b0;
            end
        endcase
    end

    // State, counters and verdict registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {ADDR_W{1'b0}};
            err_r   <= {CNT_W{1'b0}};
            fidx_r  <= {ADDR_W{1'b0}};
            fvld_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            err_r   <= err_nxt_s;
            fidx_r  <= fidx_nxt_s;
            fvld_r  <= fvld_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            pass_r  <= pass_nxt_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_r;
    assign first_err_idx = fidx_r;
    assign first_err_vld = fvld_r;

endmodule

// File: tb/tb_fsm_resp_checker.sv
// Scoreboard bench: each pass pushes its hand-computed verdict; a monitor
// pops and compares whenever done rises. A second instance with a 4-bit
// counter shares all inputs to exercise saturation.
module tb_fsm_resp_checker;
    import fsm_tb_pkg::*;

    localparam int D = 200;

    logic        clk = 1'b0;
    logic        rst, exp_we, start, smp;
    logic [7:0]  exp_addr;
    logic [18:0] exp_data, exp_mask, dut_out;
    logic        busy, done, pass, first_err_vld;
    logic [15:0] err_count;
    logic [7:0]  first_err_idx;
    logic        s_busy, s_done, s_pass, s_fvld;
    logic [3:0]  s_err;
    logic [7:0]  s_fidx;

    typedef struct {
        logic [15:0] err;
        logic [7:0]  fidx;
        logic        fvld;
        logic        pass;
        logic [3:0]  serr;
    } exp_t;

    exp_t        sb_q[$];
    logic [18:0] flip [D];
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fsm_resp_checker #(.OUT_LEN(19), .DEPTH(200), .ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_mask(exp_mask), .start(start), .smp(smp),
        .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_vld(first_err_vld));

    fsm_resp_checker #(.OUT_LEN(19), .DEPTH(200), .ADDR_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .exp_we(exp_we), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_mask(exp_mask), .start(start), .smp(smp),
        .dut_out(dut_out), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .first_err_idx(s_fidx), .first_err_vld(s_fvld));

    function automatic logic [18:0] pat(input int i);
        return 19'(i * 7919) ^ 19'h2A5C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic clear_flips();
        for (int i = 0; i < D; i++) flip[i] = 19'h0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Drive all DEPTH samples; gap mode inserts idle cycles plus ignored controls.
    task automatic run_samples(input bit gap);
        for (int i = 0; i < D; i++) begin
            smp = 1'b1;
            dut_out = pat(i) ^ flip[i];
            if (gap && i == 40) begin
                exp_we = 1'b1; exp_addr = 8'd60;
                exp_data = ~pat(60); exp_mask = 19'h7FFFF;
            end
            @(negedge clk);
            smp = 1'b0; exp_we = 1'b0;
            if (gap) begin
                if (i == 100) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_timeout: actual=no_done required=done", nm);
            sb_q.delete();
        end
    endtask

    // Monitor: compare the verdict against the scoreboard on each done rise.
    initial begin
        logic dq;
        exp_t e;
        dq = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !dq) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_done: actual=1 required=0");
                end else begin
                    e = sb_q.pop_front();
                    chk("err_count", 32'(err_count), 32'(e.err));
                    chk("first_err_idx", 32'(first_err_idx), 32'(e.fidx));
                    chk("first_err_vld", 32'(first_err_vld), 32'(e.fvld));
                    chk("pass", 32'(pass), 32'(e.pass));
                    chk("busy_at_done", 32'(busy), 32'd0);
                    chk("sat_err_count", 32'(s_err), 32'(e.serr));
                    chk("sat_first_err_idx", 32'(s_fidx), 32'(e.fidx));
                end
            end
            dq = done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; exp_we = 1'b0; exp_addr = 8'd0; exp_data = 19'h0;
        exp_mask = 19'h0; start = 1'b0; smp = 1'b0; dut_out = 19'h0;
        clear_flips();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_fidx", 32'(first_err_idx), 32'd0);
        chk("rst_fvld", 32'(first_err_vld), 32'd0);

        // Load table; also an out-of-range write that must be dropped.
        for (int i = 0; i < D; i++) begin
            exp_we = 1'b1; exp_addr = 8'(i); exp_data = pat(i); exp_mask = 19'h7FFFF;
            @(negedge clk);
        end
        exp_addr = 8'd210; exp_data = 19'h0;
        @(negedge clk);
        exp_we = 1'b0;

        // Test 1: all match, back-to-back; done visible right after last sample edge.
        sb_q.push_back('{16'd0, 8'd0, 1'b0, 1'b1, 4'd0});
        pulse_start();
        chk("t1_busy_rise", 32'(busy), 32'd1);
        run_samples(1'b0);
        chk("t1_done_latency", 32'(done), 32'd1);
        wait_drain("t1");

        // Test 2: two injected errors.
        clear_flips();
        flip[17] = 19'h8; flip[150] = 19'h40000;
        sb_q.push_back('{16'd2, 8'd17, 1'b1, 1'b0, 4'd2});
        pulse_start();
        chk("t2_done_cleared", 32'(done), 32'd0);
        run_samples(1'b0);
        wait_drain("t2");

        // Test 3: mask idx 5 low nibble; write in same cycle as start.
        clear_flips();
        flip[5] = 19'hF;
        sb_q.push_back('{16'd0, 8'd0, 1'b0, 1'b1, 4'd0});
        @(negedge clk);
        exp_we = 1'b1; exp_addr = 8'd5; exp_data = pat(5); exp_mask = 19'h7FFF0; start = 1'b1;
        @(negedge clk);
        exp_we = 1'b0; start = 1'b0;
        run_samples(1'b0);
        wait_drain("t3");

        // Test 4: smp gaps, write in RUN and start in RUN both ignored.
        clear_flips();
        sb_q.push_back('{16'd0, 8'd0, 1'b0, 1'b1, 4'd0});
        pulse_start();
        run_samples(1'b1);
        wait_drain("t4");

        // Test 5: reset mid-run of a failing pass, then retry with matching data.
        for (int i = 0; i < D; i++) flip[i] = 19'h40000;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            smp = 1'b1; dut_out = pat(i) ^ flip[i];
            @(negedge clk);
        end
        smp = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_pass", 32'(pass), 32'd0);
        chk("t5_err", 32'(err_count), 32'd0);
        chk("t5_fidx", 32'(first_err_idx), 32'd0);
        chk("t5_fvld", 32'(first_err_vld), 32'd0);
        repeat (10) @(negedge clk);
        clear_flips();
        sb_q.push_back('{16'd0, 8'd0, 1'b0, 1'b1, 4'd0});
        pulse_start();
        run_samples(1'b0);
        wait_drain("t5");

        // Test 6: every sample mismatches (bit 18 is compared everywhere).
        for (int i = 0; i < D; i++) flip[i] = 19'h40000;
        sb_q.push_back('{16'd200, 8'd0, 1'b1, 1'b0, 4'hF});
        pulse_start();
        run_samples(1'b0);
        wait_drain("t6");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
